axis_pkt_rr_arbiter: RTL and testbench

Packet-granular round-robin arbiter sharing one AXI4-Stream master between NUM_SRC stream sources, such as several packetizer instances feeding one DMA/FIFO.
- Grant is held for a whole packet, released on the accepted tlast beat, then rotated.
- Data path is combinational pass-through of the granted source; only arbitration state is registered.

---
 rtl/axis_arb_pkg.sv | 13 +
 rtl/rr_pick.sv | 34 +++
 rtl/axis_pkt_rr_arbiter.sv | 146 ++++++++++++++
 tb/tb_axis_pkt_rr_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_arb_pkg.sv
// Shared types for the packet round-robin arbiter: FSM state and index-width helper.
package axis_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority pick: first requester strictly after last_idx, with wrap-around.
// Purely combinational; gnt is one-hot and gnt_vld is low when nothing requests.
module rr_pick
    import axis_arb_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = idx_width(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   last_idx,
    output logic [NUM_SRC-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_vld
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        cand    = '0;
        // Offset NUM_SRC lands back on last_idx, so it is lowest priority.
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = IDX_W'((int'(last_idx) + k) % NUM_SRC);
            if (!gnt_vld && req[cand]) begin
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
                gnt_vld   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_pkt_rr_arbiter.sv
// Packet-granular round-robin AXI4-Stream arbiter; data is a combinational pass-through.
// One idle arbitration cycle per packet; only the granted source sees m_tready, others hold.
// AXIS_ARB_PKT_LIMIT_EN adds a MAX_PKT_BEATS packet cap with forced tlast and sticky ovf_err.
module axis_pkt_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter int NUM_SRC       = 4,
    parameter int DATA_WIDTH    = 64,
    parameter int MAX_PKT_BEATS = 524288
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_SRC-1:0]            s_tvalid,
    input  logic [NUM_SRC-1:0]            s_tlast,
    output logic [NUM_SRC-1:0]            s_tready,
    output logic [DATA_WIDTH-1:0]         m_tdata,
    output logic                          m_tvalid,
    output logic                          m_tlast,
    input  logic                          m_tready,
    output logic [NUM_SRC-1:0]            grant,
    output logic                          busy
`ifdef AXIS_ARB_PKT_LIMIT_EN
    ,
    output logic                          ovf_err
`endif
);

    localparam int IDX_W = idx_width(NUM_SRC);
    localparam int CNT_W = $clog2(MAX_PKT_BEATS) + 1;

    arb_state_t         state_q, state_d;
    logic [NUM_SRC-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

    logic [NUM_SRC-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_vld;
    logic               active;
    logic               accept;
    logic               limit_hit;

    rr_pick #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req      (s_tvalid),
        .last_idx (last_q),
        .gnt      (pick_gnt),
        .gnt_idx  (pick_idx),
        .gnt_vld  (pick_vld)
    );

    // Gating on rst_n keeps the master quiet during a reset cycle, not just after it.
    assign active = rst_n && (state_q == BUSY);
    assign accept = m_tvalid && m_tready;

`ifdef AXIS_ARB_PKT_LIMIT_EN
    logic ovf_q;

    assign limit_hit = active && s_tvalid[gidx_q] && !s_tlast[gidx_q]
                    && (beat_cnt_q == CNT_W'(MAX_PKT_BEATS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (accept && limit_hit) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf_err = ovf_q;
`else
    logic unused_cnt;

    assign limit_hit  = 1'b0;
    assign unused_cnt = ^beat_cnt_q;
`endif

    always_comb begin
        m_tdata  = '0;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        s_tready = '0;
        if (active) begin
            m_tvalid = s_tvalid[gidx_q];
            m_tlast  = s_tlast[gidx_q] | limit_hit;
            s_tready = grant_q & {NUM_SRC{m_tready}};
            if (s_tvalid[gidx_q]) begin
                m_tdata = s_tdata[int'(gidx_q)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        gidx_d     = gidx_q;
        last_d     = last_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d    = BUSY;
                    grant_d    = pick_gnt;
                    gidx_d     = pick_idx;
                    beat_cnt_d = '0;
                end
            end
            BUSY: begin
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (m_tlast) begin
                        state_d    = IDLE;
                        grant_d    = '0;
                        last_d     = gidx_q;
                        beat_cnt_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            gidx_q     <= '0;
            last_q     <= IDX_W'(NUM_SRC - 1);
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            gidx_q     <= gidx_d;
            last_q     <= last_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q == BUSY);

endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// Scoreboard bench for axis_pkt_rr_arbiter: source models feed queued packets, a monitor
// checks every accepted master beat against the expected order.
module tb_axis_pkt_rr_arbiter;

    localparam int NSRC = 4;
    localparam int DW   = 64;
`ifdef AXIS_ARB_PKT_LIMIT_EN
    localparam int LIMIT = 4;
`else
    localparam int LIMIT = 524288;
`endif

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
        logic [3:0]  grant;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NSRC*DW-1:0] s_tdata;
    logic [NSRC-1:0]    s_tvalid;
    logic [NSRC-1:0]    s_tlast;
    logic [NSRC-1:0]    s_tready;
    logic [DW-1:0]      m_tdata;
    logic               m_tvalid;
    logic               m_tlast;
    logic               m_tready;
    logic [NSRC-1:0]    grant;
    logic               busy;
`ifdef AXIS_ARB_PKT_LIMIT_EN
    logic               ovf_err;
`endif

    beat_t           src_q[NSRC][$];
    exp_t            exp_q[$];
    logic [NSRC-1:0] hold;
    logic [NSRC-1:0] seen_rdy;
    int              n_checks = 0;
    int              n_pass   = 0;
    int              acc_cnt  = 0;

    axis_pkt_rr_arbiter #(
        .NUM_SRC       (NSRC),
        .DATA_WIDTH    (DW),
        .MAX_PKT_BEATS (LIMIT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tlast  (s_tlast),
        .s_tready (s_tready),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tlast  (m_tlast),
        .m_tready (m_tready),
        .grant    (grant),
        .busy     (busy)
`ifdef AXIS_ARB_PKT_LIMIT_EN
        ,
        .ovf_err  (ovf_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    function automatic logic [63:0] mk_data(input int src, input int pkt, input int beat);
        return {8'hD0, 24'(src), 16'(pkt), 16'(beat)};
    endfunction

    task automatic exp_push(input int src, input int pkt, input int beat, input logic last);
        exp_t e;
        e.data  = mk_data(src, pkt, beat);
        e.last  = last;
        e.grant = 4'(1 << src);
        exp_q.push_back(e);
    endtask

    // Expected tlast also lands where the beat cap would cut a long packet.
    task automatic push_pkt(input int src, input int pkt, input int n);
        int run;
        run = 0;
        for (int b = 0; b < n; b++) begin
            beat_t bt;
            logic  el;
            bt.data = mk_data(src, pkt, b);
            bt.last = (b == n - 1);
            src_q[src].push_back(bt);
            run++;
            el = (b == n - 1) || (run == LIMIT);
            if (el) run = 0;
            exp_push(src, pkt, b, el);
        end
    endtask

    function automatic bit drained();
        bit d;
        d = (exp_q.size() == 0);
        for (int i = 0; i < NSRC; i++) if (src_q[i].size() != 0) d = 0;
        return d;
    endfunction

    task automatic wait_drain(input string name);
        for (int c = 0; c < 200 && !drained(); c++) begin
            @(negedge clk); #1;
            seen_rdy = seen_rdy | s_tready;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic wait_exp(input int n, input string name);
        for (int c = 0; c < 200 && exp_q.size() != n; c++) begin
            @(negedge clk); #1;
        end
        check(name, exp_q.size(), n);
    endtask

    task automatic wait_busy(input string name);
        for (int c = 0; c < 50 && !busy; c++) begin
            @(negedge clk); #1;
        end
        check(name, busy, 1);
    endtask

    // Source models: handshake seen at negedge, queue advanced just after posedge.
    initial begin
        logic [NSRC-1:0] took;
        s_tvalid = '0;
        s_tlast  = '0;
        s_tdata  = '0;
        forever begin
            @(negedge clk);
            took = s_tvalid & s_tready;
            @(posedge clk); #1;
            for (int i = 0; i < NSRC; i++) begin
                if (took[i] && src_q[i].size() > 0) src_q[i].delete(0);
                if (src_q[i].size() > 0 && !hold[i]) begin
                    s_tvalid[i]         = 1'b1;
                    s_tlast[i]          = src_q[i][0].last;
                    s_tdata[i*DW +: DW] = src_q[i][0].data;
                end else begin
                    s_tvalid[i]         = 1'b0;
                    s_tlast[i]          = 1'b0;
                    s_tdata[i*DW +: DW] = '0;
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && m_tvalid && m_tready) begin
                acc_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected beat: got data %h grant %b, required no beat", m_tdata, grant);
                end else begin
                    e = exp_q.pop_front();
                    check("beat tdata", m_tdata, e.data);
                    check("beat tlast", m_tlast, e.last);
                    check("beat grant", grant, e.grant);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached with %0d expected beats pending", exp_q.size());
        $fatal(1);
    end

    initial begin
        int idle;
        int a0;
        rst_n    = 1'b0;
        m_tready = 1'b1;
        hold     = '0;
        seen_rdy = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("reset m_tvalid", m_tvalid, 0);
        check("reset m_tlast", m_tlast, 0);
        check("reset s_tready", s_tready, 0);
        check("reset m_tdata", m_tdata, 0);
        check("reset grant", grant, 0);
        check("reset busy", busy, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk); #1;

        // All four sources, 3-beat packets: order 0,1,2,3,0 with one bubble between packets.
        push_pkt(0, 1, 3);
        push_pkt(1, 2, 3);
        push_pkt(2, 3, 3);
        push_pkt(3, 4, 3);
        push_pkt(0, 5, 3);
        wait_busy("t1 first grant");
        idle = 0;
        for (int c = 0; c < 19; c++) begin
            if (!busy) idle++;
            @(negedge clk); #1;
        end
        check("t1 idle cycles", idle, 4);
        check("t1 busy after last", busy, 0);
        wait_drain("t1 drain");

        // Lone requester src2: two 4-beat packets, other readies stay low.
        seen_rdy = '0;
        push_pkt(2, 10, 4);
        push_pkt(2, 11, 4);
        wait_drain("t2 drain");
        check("t2 other s_tready", seen_rdy & 4'b1011, 0);
        check("t2 src2 s_tready", seen_rdy[2], 1);

        // src1 5-beat packet with m_tready toggling every cycle.
        a0 = acc_cnt;
        push_pkt(1, 20, 5);
        for (int c = 0; c < 80 && !drained(); c++) begin
            @(posedge clk); #1 m_tready = ~m_tready;
            @(negedge clk); #1;
            if (busy) check("t3 grant held", grant, 4'b0010);
            if (m_tvalid && !m_tready && exp_q.size() > 0)
                check("t3 stalled tdata", m_tdata, exp_q[0].data);
        end
        m_tready = 1'b1;
        wait_drain("t3 drain");
        check("t3 accepted beats", acc_cnt - a0, 5);

        // src0 stalls 3 cycles mid-packet while src1 waits.
        push_pkt(0, 30, 4);
        push_pkt(1, 31, 2);
        wait_exp(4, "t4 two beats");
        hold[0] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            check("t4 grant kept", grant, 4'b0001);
            check("t4 m_tvalid low", m_tvalid, 0);
            check("t4 m_tdata zero", m_tdata, 0);
        end
        hold[0] = 1'b0;
        wait_drain("t4 drain");

        // Reset on beat 2 of a src3 packet; arbitration restarts at src0.
        push_pkt(3, 50, 4);
        wait_exp(2, "t5 two beats");
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_q.delete();
        push_pkt(0, 51, 2);
        exp_push(3, 50, 2, 1'b0);
        exp_push(3, 50, 3, 1'b1);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk); #1;
        check("t5 m_tvalid", m_tvalid, 0);
        check("t5 grant", grant, 0);
        check("t5 busy", busy, 0);
        @(negedge clk); #1;
        check("t5 first grant", grant, 4'b0001);
        wait_drain("t5 drain");

`ifdef AXIS_ARB_PKT_LIMIT_EN
        // 6-beat packet against a 4-beat cap: tlast forced on beat 4, ovf_err sticky.
        check("t6 ovf before", ovf_err, 0);
        push_pkt(0, 60, 6);
        wait_exp(2, "t6 four beats");
        check("t6 ovf not early", ovf_err, 0);
        @(negedge clk); #1;
        check("t6 ovf set", ovf_err, 1);
        wait_drain("t6 drain");
        check("t6 ovf sticky", ovf_err, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
